// File: rtl/video_timing_gen.sv
// ---------------------------------------------------------------------------
// video_timing_gen
//
// Raster timing generator for the pixel-clock domain. It walks a horizontal
// counter (hcnt) and vertical counter (vcnt) across the full blanked raster.
// From those counters it produces sync, data-enable and pixel coordinates for
// the TMDS output path. It also issues one line-fetch request per active line
// to the memory-side line buffer. A late acknowledge sets a sticky underflow
// flag.
//
// Ports
//   video_clk     in   pixel clock (single clock domain)
//   reset_n       in   synchronous, active-low reset
//   hsync         out  horizontal sync, active level HS_POL
//   vsync         out  vertical sync, active level VS_POL, line aligned
//   de            out  data enable, high for active pixels
//   pixel_x       out  column of current pixel, 0 when de is low
//   pixel_y       out  row of current pixel, 0 when de is low
//   frame_start   out  one-cycle pulse with de for pixel (0,0)
//   line_req      out  line-fetch request level, held until acknowledged
//   line_req_num  out  line number being requested, stable while line_req
//   line_ack      in   memory side accepted the outstanding request
//   underflow     out  sticky: a line fetch was not acknowledged in time
//
// Every output is registered from the counter state. As a result, all
// outputs lag the counters by exactly one cycle and stay aligned with one
// another.
// ---------------------------------------------------------------------------
module video_timing_gen #(
   parameter int H_ACTIVE = 1280,
   parameter int H_FP     = 110,
   parameter int H_SYNC   = 40,
   parameter int H_BP     = 220,
   parameter int V_ACTIVE = 720,
   parameter int V_FP     = 5,
   parameter int V_SYNC   = 5,
   parameter int V_BP     = 20,
   parameter bit HS_POL   = 1'b1,
   parameter bit VS_POL   = 1'b1
) (
   input  logic        video_clk,
   input  logic        reset_n,
   output logic        hsync,
   output logic        vsync,
   output logic        de,
   output logic [11:0] pixel_x,
   output logic [11:0] pixel_y,
   output logic        frame_start,
   output logic        line_req,
   output logic [11:0] line_req_num,
   input  logic        line_ack,
   output logic        underflow
);

   localparam int CW      = 12;
   localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
   localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

   localparam logic [CW-1:0] H_ACT_C  = CW'(H_ACTIVE);
   localparam logic [CW-1:0] H_SYN_S  = CW'(H_ACTIVE + H_FP);
   localparam logic [CW-1:0] H_SYN_E  = CW'(H_ACTIVE + H_FP + H_SYNC);
   localparam logic [CW-1:0] H_LAST_C = CW'(H_TOTAL - 1);
   localparam logic [CW-1:0] V_ACT_C  = CW'(V_ACTIVE);
   localparam logic [CW-1:0] V_SYN_S  = CW'(V_ACTIVE + V_FP);
   localparam logic [CW-1:0] V_SYN_E  = CW'(V_ACTIVE + V_FP + V_SYNC);
   localparam logic [CW-1:0] V_LAST_C = CW'(V_TOTAL - 1);

   // Counter state
   logic [CW-1:0] hcnt_q, hcnt_d;
   logic [CW-1:0] vcnt_q, vcnt_d;

   // Registered outputs
   logic          hsync_q, hsync_d;
   logic          vsync_q, vsync_d;
   logic          de_q, de_d;
   logic [CW-1:0] pixel_x_q, pixel_x_d;
   logic [CW-1:0] pixel_y_q, pixel_y_d;
   logic          frame_start_q, frame_start_d;
   logic          line_req_q, line_req_d;
   logic [CW-1:0] line_req_num_q, line_req_num_d;
   logic          underflow_q, underflow_d;

   // Decode helpers
   logic [CW-1:0] next_line;
   logic          h_act, v_act;
   logic          req_point;
   logic          deadline_miss;

   // Raster counters
   always_comb begin
      hcnt_d = hcnt_q + 1'b1;
      vcnt_d = vcnt_q;
      if (hcnt_q == H_LAST_C) begin
         hcnt_d = '0;
         vcnt_d = next_line;
      end
   end

   assign next_line = (vcnt_q == V_LAST_C) ? '0 : vcnt_q + 1'b1;

   // Raster decode
   always_comb begin
      h_act         = (hcnt_q < H_ACT_C);
      v_act         = (vcnt_q < V_ACT_C);
      de_d          = h_act && v_act;
      pixel_x_d     = de_d ? hcnt_q : '0;
      pixel_y_d     = de_d ? vcnt_q : '0;
      hsync_d       = ((hcnt_q >= H_SYN_S) && (hcnt_q < H_SYN_E)) ? HS_POL : ~HS_POL;
      // vcnt only moves when hcnt wraps, so vsync edges land on line starts.
      vsync_d       = ((vcnt_q >= V_SYN_S) && (vcnt_q < V_SYN_E)) ? VS_POL : ~VS_POL;
      frame_start_d = (hcnt_q == '0) && (vcnt_q == '0);
   end

   // Line-fetch handshake and underflow detection
   always_comb begin
      // Request at the end of active video, for the line that comes next,
      // only when that next line is itself an active line.
      req_point = (hcnt_q == H_ACT_C) && (next_line < V_ACT_C);
      // The line we asked for is starting and the fetch is still outstanding.
      // After reset line_req_q is low, so the first line of the first frame
      // never trips this.
      deadline_miss = (hcnt_q == '0) && v_act && line_req_q &&
                      (line_req_num_q == vcnt_q);

      line_req_d     = line_req_q;
      line_req_num_d = line_req_num_q;
      underflow_d    = underflow_q;

      if (line_req_q && line_ack) begin
         line_req_d = 1'b0;
      end
      // A new request overrides a same-cycle acknowledge. The stale request
      // is abandoned and the underflow is flagged.
      if (req_point) begin
         line_req_d     = 1'b1;
         line_req_num_d = next_line;
         if (line_req_q) begin
            underflow_d = 1'b1;
         end
      end
      if (deadline_miss) begin
         underflow_d = 1'b1;
      end
   end

   always_ff @(posedge video_clk) begin
      if (!reset_n) begin
         hcnt_q         <= '0;
         vcnt_q         <= '0;
         hsync_q        <= ~HS_POL;
         vsync_q        <= ~VS_POL;
         de_q           <= 1'b0;
         pixel_x_q      <= '0;
         pixel_y_q      <= '0;
         frame_start_q  <= 1'b0;
         line_req_q     <= 1'b0;
         line_req_num_q <= '0;
         underflow_q    <= 1'b0;
      end else begin
         hcnt_q         <= hcnt_d;
         vcnt_q         <= vcnt_d;
         hsync_q        <= hsync_d;
         vsync_q        <= vsync_d;
         de_q           <= de_d;
         pixel_x_q      <= pixel_x_d;
         pixel_y_q      <= pixel_y_d;
         frame_start_q  <= frame_start_d;
         line_req_q     <= line_req_d;
         line_req_num_q <= line_req_num_d;
         underflow_q    <= underflow_d;
      end
   end

   assign hsync        = hsync_q;
   assign vsync        = vsync_q;
   assign de           = de_q;
   assign pixel_x      = pixel_x_q;
   assign pixel_y      = pixel_y_q;
   assign frame_start  = frame_start_q;
   assign line_req     = line_req_q;
   assign line_req_num = line_req_num_q;
   assign underflow    = underflow_q;

endmodule

// File: tb/tb_video_timing_gen.sv
// ---------------------------------------------------------------------------
// tb_video_timing_gen
//
// Directed bench for video_timing_gen. It uses a shrunken raster so that whole
// frames fit in a short run:
//   horizontal 16 active, 4 fp, 3 sync, 5 bp    -> 28 cycles per line,
//                                                  hsync at cycles 20..22
//   vertical    6 active, 2 fp, 2 sync, 2 bp    -> 12 lines per frame,
//                                                  vsync on lines 8..9
//   frame = 336 cycles; request window = 12 cycles
// HS_POL=1 and VS_POL=0, so the two sync polarities are distinguishable.
// t counts output cycles; t=0 is the frame_start pulse.
// ---------------------------------------------------------------------------
module tb_video_timing_gen;

   localparam int HT = 28;
   localparam int VT = 12;
   localparam int FR = HT * VT;

   logic        video_clk = 1'b0;
   logic        reset_n;
   logic        hsync, vsync, de, frame_start, line_req, underflow;
   logic [11:0] pixel_x, pixel_y, line_req_num;
   logic        line_ack;

   int checks = 0;
   int errors = 0;
   int t      = 0;
   int k      = 0;
   bit ack_en = 1'b0;
   int ack_dly = 10;

   // frame statistics
   int h, v;
   int de_cnt = 0, de_bad = 0, pix_bad = 0;
   int hs_cnt = 0, hs_first = -1;
   int vs_cnt = 0, vs_first = -1;
   int de_fall = -1, de_rise2 = -1;
   int fs_cnt = 0;
   int fs_t[4];
   int req_cnt = 0, req_first = -1, nreq = 0;
   int nums[16];
   bit prev_req = 1'b0, prev_de = 1'b0, uf_any = 1'b0;

   always #5 video_clk = ~video_clk;

   video_timing_gen #(
      .H_ACTIVE(16), .H_FP(4), .H_SYNC(3), .H_BP(5),
      .V_ACTIVE(6),  .V_FP(2), .V_SYNC(2), .V_BP(2),
      .HS_POL(1'b1), .VS_POL(1'b0)
   ) dut (
      .video_clk   (video_clk),
      .reset_n     (reset_n),
      .hsync       (hsync),
      .vsync       (vsync),
      .de          (de),
      .pixel_x     (pixel_x),
      .pixel_y     (pixel_y),
      .frame_start (frame_start),
      .line_req    (line_req),
      .line_req_num(line_req_num),
      .line_ack    (line_ack),
      .underflow   (underflow)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   // Advance one clock and sample 1 time unit after the edge. When enabled,
   // the responder raises line_ack on the ack_dly-th sampled cycle of a request.
   task automatic tick();
      @(posedge video_clk);
      #1;
      t++;
      if (ack_en) begin
         if (line_req) begin
            k++;
            line_ack = (k == ack_dly);
         end else begin
            k = 0;
            line_ack = 1'b0;
         end
      end
   endtask

   task automatic tick_to(input int target);
      while (t < target) tick();
   endtask

   task automatic chk_reset_vals(input string pfx);
      chk({pfx, "_hsync"}, hsync, 0);
      chk({pfx, "_vsync"}, vsync, 1);
      chk({pfx, "_de"}, de, 0);
      chk({pfx, "_px"}, pixel_x, 0);
      chk({pfx, "_py"}, pixel_y, 0);
      chk({pfx, "_fs"}, frame_start, 0);
      chk({pfx, "_req"}, line_req, 0);
      chk({pfx, "_num"}, line_req_num, 0);
      chk({pfx, "_uf"}, underflow, 0);
   endtask

   initial begin
      reset_n  = 1'b0;
      line_ack = 1'b0;

      // Reset held for 5 cycles
      repeat (5) tick();
      chk_reset_vals("rst");

      // Release: the first output cycle shows pixel (0,0)
      reset_n = 1'b1;
      t = -1;
      tick();
      chk("rel_fs", frame_start, 1);
      chk("rel_de", de, 1);
      chk("rel_px", pixel_x, 0);
      chk("rel_py", pixel_y, 0);

      // Two frames with the ack responder at 10 cycles per request
      ack_en = 1'b1;
      k = 0;
      while (t < 2 * FR) begin
         h = t % HT;
         v = (t / HT) % VT;
         if (t == 1) chk("t1_px", pixel_x, 1);
         if (de) de_cnt++;
         if (de && v >= 6) de_bad++;
         if (de && (pixel_x != 12'(h) || pixel_y != 12'(v))) pix_bad++;
         if (!de && (pixel_x != 0 || pixel_y != 0)) pix_bad++;
         if (!de && prev_de && de_fall < 0) de_fall = t;
         if (de && !prev_de && de_fall >= 0 && de_rise2 < 0) de_rise2 = t;
         if (hsync) begin
            hs_cnt++;
            if (hs_first < 0) hs_first = t;
         end
         if (!vsync) begin
            vs_cnt++;
            if (vs_first < 0) vs_first = t;
         end
         if (frame_start) begin
            if (fs_cnt < 4) fs_t[fs_cnt] = t;
            fs_cnt++;
         end
         if (line_req) begin
            req_cnt++;
            if (!prev_req) begin
               if (req_first < 0) req_first = t;
               if (nreq < 16) nums[nreq] = int'(line_req_num);
               nreq++;
            end
         end
         if (underflow) uf_any = 1'b1;
         prev_req = line_req;
         prev_de  = de;
         tick();
      end
      chk("de_count", de_cnt, 192);
      chk("de_blank_lines", de_bad, 0);
      chk("pixel_coords", pix_bad, 0);
      chk("de_fall", de_fall, 16);
      chk("de_rise2", de_rise2, 28);
      chk("hs_count", hs_cnt, 72);
      chk("hs_first", hs_first, 20);
      chk("vs_count", vs_cnt, 112);
      chk("vs_first", vs_first, 224);
      chk("fs_count", fs_cnt, 2);
      chk("fs_spacing", fs_t[1] - fs_t[0], FR);
      chk("req_first", req_first, 16);
      chk("req_high_cycles", req_cnt, 120);
      chk("req_count", nreq, 12);
      chk("req_num0", nums[0], 1);
      chk("req_num4", nums[4], 5);
      chk("req_num5", nums[5], 0);
      chk("req_num11", nums[11], 0);
      chk("uf_two_frames", uf_any, 0);

      // Late ack: withhold across the start of line 1, then across the next request point
      ack_en   = 1'b0;
      line_ack = 1'b0;
      tick_to(2 * FR + HT - 1);
      chk("late_uf_before", underflow, 0);
      chk("late_req", line_req, 1);
      chk("late_num1", line_req_num, 1);
      tick();
      chk("late_uf_set", underflow, 1);
      tick_to(2 * FR + HT + 15);
      chk("late_num_hold", line_req_num, 1);
      tick();
      chk("late_num_adv", line_req_num, 2);
      chk("late_req_still", line_req, 1);

      // Acks resume; underflow stays set
      ack_en = 1'b1;
      k = 0;
      tick_to(2 * FR + 3 * HT + 14);
      chk("resume_req_low", line_req, 0);
      tick_to(2 * FR + 3 * HT + 20);
      chk("resume_req", line_req, 1);
      chk("resume_num", line_req_num, 4);
      chk("resume_uf", underflow, 1);

      // Mid-frame reset with a request pending
      reset_n  = 1'b0;
      ack_en   = 1'b0;
      line_ack = 1'b0;
      k = 0;
      tick();
      chk_reset_vals("mid");

      // Restart; line_ack held high while no request is outstanding is ignored
      reset_n  = 1'b1;
      line_ack = 1'b1;
      t = -1;
      tick();
      chk("mid_fs", frame_start, 1);
      chk("mid_de", de, 1);
      chk("mid_px", pixel_x, 0);
      tick_to(15);
      chk("ign_ack_req_low", line_req, 0);
      tick();
      chk("ign_ack_req", line_req, 1);
      chk("ign_ack_num", line_req_num, 1);
      tick();
      chk("ack_drop", line_req, 0);
      line_ack = 1'b0;
      tick_to(HT);
      chk("mid_uf", underflow, 0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
